// File: rtl/note_judge_if.sv
// note_judge_if
//   Bundles the game-side signals of the note judgement stage.
//   Inputs to the judge : Run, K_Press
//   Outputs of the judge: frame, BallEN, Perfect, Miss, Combo, dbg_state
//
//   Flow control: there is no valid/ready pair on this bus. Run is the only
//   qualifier. While Run is high, K_Press is sampled on every frame_clk edge.
//   The one-cycle pulses (BallEN, Perfect, Miss) are valid for exactly the
//   cycle in which they are high, and the consumer cannot stall them.
//   frame and Combo are level outputs that are valid in every cycle.
//
//   dbg_state exposes the judge FSM: 0 = WAIT, 1 = OPEN, 2 = DONE.
interface note_judge_if;
  logic       Run;
  logic       K_Press;
  logic [3:0] frame;
  logic       BallEN;
  logic       Perfect;
  logic       Miss;
  logic [9:0] Combo;
  logic [1:0] dbg_state;

  modport master (
    output Run,
    output K_Press,
    input  frame,
    input  BallEN,
    input  Perfect,
    input  Miss,
    input  Combo,
    input  dbg_state
  );

  modport slave (
    input  Run,
    input  K_Press,
    output frame,
    output BallEN,
    output Perfect,
    output Miss,
    output Combo,
    output dbg_state
  );
endinterface

// File: rtl/note_judge.sv
// note_judge
//   Timing and judgement stage of the rhythm game. It runs the per-note beat
//   counter and derives the 4-bit frame phase from it. It grades key presses
//   against the hit window around the centre of each note period.
//
//   Ports:
//     frame_clk : clock, one tick per video frame
//     Reset     : synchronous, active-high reset
//     bus       : note_judge_if.slave
//                 Run, K_Press in
//                 frame, BallEN, Perfect, Miss, Combo, dbg_state out
//
//   The pulses are registered. They appear in the cycle after the judged
//   cycle. Combo changes in that same cycle.
module note_judge #(
  parameter int NOTE_PERIOD = 32,
  parameter int WIN         = 3,
  parameter int COMBO_MAX   = 999
) (
  input  logic         frame_clk,
  input  logic         Reset,
  note_judge_if.slave  bus
);

  localparam int CW = $clog2(NOTE_PERIOD);

  localparam logic [CW-1:0] TARGET   = CW'(NOTE_PERIOD / 2);
  localparam logic [CW-1:0] OPEN_AT  = CW'(NOTE_PERIOD / 2 - WIN - 1);
  localparam logic [CW-1:0] CLOSE_AT = CW'(NOTE_PERIOD / 2 + WIN);
  localparam logic [CW-1:0] LAST     = CW'(NOTE_PERIOD - 1);
  localparam logic [9:0]    COMBO_SAT = 10'(COMBO_MAX);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_OPEN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q,   state_d;
  logic [CW-1:0] beat_q,    beat_d;
  logic [9:0]    combo_q,   combo_d;
  logic          k_prev_q,  k_prev_d;
  logic          ball_en_q, ball_en_d;
  logic          perfect_q, perfect_d;
  logic          miss_q,    miss_d;

  logic          press;
  logic [9:0]    combo_inc;

  assign press     = bus.K_Press & ~k_prev_q;
  assign combo_inc = (combo_q >= COMBO_SAT) ? COMBO_SAT : combo_q + 10'd1;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    combo_d   = combo_q;
    // The edge detector keeps tracking the key while the game is frozen.
    // A key that is pressed and held during a pause therefore is not seen
    // as a fresh press when Run returns.
    k_prev_d  = bus.K_Press;
    ball_en_d = 1'b0;
    perfect_d = 1'b0;
    miss_d    = 1'b0;

    if (bus.Run) begin
      // NOTE_PERIOD is a power of two, so the counter wraps by overflowing.
      beat_d = beat_q + CW'(1);

      unique case (state_q)
        ST_WAIT: begin
          if (press) begin
            miss_d  = 1'b1;
            combo_d = 10'd0;
          end else if (beat_q == OPEN_AT) begin
            state_d = ST_OPEN;
          end
        end
        ST_OPEN: begin
          // A press on the last window cycle counts as a hit.
          if (press) begin
            ball_en_d = 1'b1;
            perfect_d = (beat_q == TARGET);
            combo_d   = combo_inc;
            state_d   = ST_DONE;
          end else if (beat_q == CLOSE_AT) begin
            miss_d  = 1'b1;
            combo_d = 10'd0;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (beat_q == LAST) begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= ST_WAIT;
      beat_q    <= '0;
      combo_q   <= 10'd0;
      // The reset value of 1 means a key held through reset does not register as a press.
      k_prev_q  <= 1'b1;
      ball_en_q <= 1'b0;
      perfect_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      combo_q   <= combo_d;
      k_prev_q  <= k_prev_d;
      ball_en_q <= ball_en_d;
      perfect_q <= perfect_d;
      miss_q    <= miss_d;
    end
  end

  // frame is the top four bits of the beat counter. This equals
  // beat >> (CW - 4).
  assign bus.frame     = beat_q[CW-1 -: 4];
  assign bus.BallEN    = ball_en_q;
  assign bus.Perfect   = perfect_q;
  assign bus.Miss      = miss_q;
  assign bus.Combo     = combo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_note_judge.sv
module tb_note_judge;
  localparam int P    = 32;
  localparam int W    = 3;
  localparam int T    = P / 2;
  localparam int CMAX = 999;

  logic frame_clk;
  logic Reset;

  note_judge_if bus();

  note_judge #(
    .NOTE_PERIOD(P),
    .WIN        (W),
    .COMBO_MAX  (CMAX)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bus      (bus)
  );

  // ---------------- clock ----------------
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // The model follows one note at a time.
  //   awaiting : the window is not open yet.
  //   armed    : the window is open.
  //   finished : the note has been judged.
  int m_beat;
  int m_combo;
  bit m_armed, m_finished, m_kprev;
  bit m_ball, m_perf, m_miss;

  // The task advances one clock edge and updates the model with the inputs
  // that were present at that edge. It then waits 1 time unit so that the
  // DUT outputs have settled.
  task automatic tick();
    bit press;
    @(posedge frame_clk);
    if (Reset) begin
      m_beat = 0; m_combo = 0; m_armed = 0; m_finished = 0; m_kprev = 1;
      m_ball = 0; m_perf = 0; m_miss = 0;
    end else begin
      press   = bus.K_Press && !m_kprev;
      m_kprev = bus.K_Press;
      m_ball = 0; m_perf = 0; m_miss = 0;
      if (bus.Run) begin
        if (m_armed) begin
          if (press) begin
            m_ball = 1;
            m_perf = (m_beat == T);
            m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
            m_armed = 0; m_finished = 1;
          end else if (m_beat == T + W) begin
            m_miss = 1; m_combo = 0;
            m_armed = 0; m_finished = 1;
          end
        end else if (m_finished) begin
          if (m_beat == P - 1) m_finished = 0;
        end else begin
          if (press) begin
            m_miss = 1; m_combo = 0;
          end else if (m_beat == T - W - 1) begin
            m_armed = 1;
          end
        end
        m_beat = (m_beat + 1) % P;
      end
    end
    #1;
  endtask

  // This task requires Run=1. It waits until the counter holds beat b, and
  // it gives up after two periods.
  task automatic wait_beat(input int b);
    int n;
    n = 0;
    while (m_beat != b && n < 2 * P) begin
      tick();
      n++;
    end
    if (m_beat != b) begin
      total++; bad++;
      $display("FAIL wait_beat timeout got=%0d required=%0d", m_beat, b);
    end
  endtask

  // The press rises while the counter holds beat b. That cycle is the
  // judged cycle, and the result is visible when the task returns.
  task automatic press_at(input int b);
    wait_beat(b);
    bus.K_Press = 1'b1;
    tick();
    bus.K_Press = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.Run = 1'b1;
    bus.K_Press = 1'b0;
    do_reset();
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL reset_ballen got=%0b required=0", bus.BallEN); end
    total++; if (bus.Perfect !== 1'b0) begin bad++; $display("FAIL reset_perfect got=%0b required=0", bus.Perfect); end
    total++; if (bus.Miss !== 1'b0) begin bad++; $display("FAIL reset_miss got=%0b required=0", bus.Miss); end
    total++; if (bus.Combo !== 10'd0) begin bad++; $display("FAIL reset_combo got=%0d required=0", bus.Combo); end
    total++; if (bus.frame !== 4'd0) begin bad++; $display("FAIL reset_frame got=%0d required=0", bus.frame); end
    total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d required=0", bus.dbg_state); end
  endtask

  task automatic test_hit_perfect();
    bus.Run = 1'b1;
    do_reset();
    press_at(16);
    total++; if (bus.BallEN !== 1'b1) begin bad++; $display("FAIL t1_ballen got=%0b required=1", bus.BallEN); end
    total++; if (bus.Perfect !== 1'b1) begin bad++; $display("FAIL t1_perfect got=%0b required=1", bus.Perfect); end
    total++; if (bus.Miss !== 1'b0) begin bad++; $display("FAIL t1_miss got=%0b required=0", bus.Miss); end
    total++; if (bus.Combo !== 10'd1) begin bad++; $display("FAIL t1_combo got=%0d required=1", bus.Combo); end
    tick();
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL t1_ballen_off got=%0b required=0", bus.BallEN); end
    total++; if (bus.Perfect !== 1'b0) begin bad++; $display("FAIL t1_perfect_off got=%0b required=0", bus.Perfect); end
  endtask

  task automatic test_back_to_back();
    bus.Run = 1'b1;
    do_reset();
    press_at(14);
    total++; if (bus.BallEN !== 1'b1) begin bad++; $display("FAIL t2_ballen got=%0b required=1", bus.BallEN); end
    total++; if (bus.Perfect !== 1'b0) begin bad++; $display("FAIL t2_perfect got=%0b required=0", bus.Perfect); end
    total++; if (bus.Combo !== 10'd1) begin bad++; $display("FAIL t2_combo got=%0d required=1", bus.Combo); end
    press_at(17);
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL t2_second_ballen got=%0b required=0", bus.BallEN); end
    total++; if (bus.Miss !== 1'b0) begin bad++; $display("FAIL t2_second_miss got=%0b required=0", bus.Miss); end
    total++; if (bus.Combo !== 10'd1) begin bad++; $display("FAIL t2_second_combo got=%0d required=1", bus.Combo); end
  endtask

  task automatic test_early_press();
    bus.Run = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_beat(0);
      press_at(15);
    end
    total++; if (bus.Combo !== 10'd4) begin bad++; $display("FAIL t3_combo4 got=%0d required=4", bus.Combo); end
    press_at(5);
    total++; if (bus.Miss !== 1'b1) begin bad++; $display("FAIL t3_miss got=%0b required=1", bus.Miss); end
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL t3_miss_ballen got=%0b required=0", bus.BallEN); end
    total++; if (bus.Combo !== 10'd0) begin bad++; $display("FAIL t3_combo0 got=%0d required=0", bus.Combo); end
    press_at(13);
    total++; if (bus.BallEN !== 1'b1) begin bad++; $display("FAIL t3_hit13 got=%0b required=1", bus.BallEN); end
    total++; if (bus.Combo !== 10'd1) begin bad++; $display("FAIL t3_combo1 got=%0d required=1", bus.Combo); end
  endtask

  task automatic test_timeout_miss();
    bus.Run = 1'b1;
    do_reset();
    press_at(16);
    wait_beat(0);
    wait_beat(19);
    total++; if (bus.Miss !== 1'b0) begin bad++; $display("FAIL t4_miss_early got=%0b required=0", bus.Miss); end
    tick();
    total++; if (bus.Miss !== 1'b1) begin bad++; $display("FAIL t4_miss got=%0b required=1", bus.Miss); end
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL t4_ballen got=%0b required=0", bus.BallEN); end
    total++; if (bus.Combo !== 10'd0) begin bad++; $display("FAIL t4_combo got=%0d required=0", bus.Combo); end
    press_at(25);
    total++; if (bus.Miss !== 1'b0) begin bad++; $display("FAIL t4_done_miss got=%0b required=0", bus.Miss); end
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL t4_done_ballen got=%0b required=0", bus.BallEN); end
  endtask

  task automatic test_combo_saturate();
    bus.Run = 1'b1;
    do_reset();
    for (int i = 0; i < CMAX; i++) begin
      wait_beat(0);
      press_at(T - W + int'($urandom_range(0, 2 * W)));
    end
    total++; if (bus.Combo !== 10'd999) begin bad++; $display("FAIL t5_combo999 got=%0d required=999", bus.Combo); end
    wait_beat(0);
    press_at(15);
    total++; if (bus.BallEN !== 1'b1) begin bad++; $display("FAIL t5_ballen got=%0b required=1", bus.BallEN); end
    total++; if (bus.Perfect !== 1'b0) begin bad++; $display("FAIL t5_perfect got=%0b required=0", bus.Perfect); end
    total++; if (bus.Combo !== 10'd999) begin bad++; $display("FAIL t5_sat got=%0d required=999", bus.Combo); end
  endtask

  task automatic test_reset_held_key();
    int balls;
    bus.Run = 1'b1;
    bus.K_Press = 1'b1;
    do_reset();
    balls = 0;
    while (m_beat != 17) begin
      tick();
      if (bus.BallEN === 1'b1) balls++;
    end
    Reset = 1'b1;
    tick();
    total++; if (bus.BallEN !== 1'b0 || bus.Perfect !== 1'b0 || bus.Miss !== 1'b0) begin bad++;
      $display("FAIL t6_reset_pulses got=%0b%0b%0b required=000", bus.BallEN, bus.Perfect, bus.Miss); end
    total++; if (bus.Combo !== 10'd0) begin bad++; $display("FAIL t6_reset_combo got=%0d required=0", bus.Combo); end
    total++; if (bus.frame !== 4'd0) begin bad++; $display("FAIL t6_reset_frame got=%0d required=0", bus.frame); end
    Reset = 1'b0;
    tick();
    total++; if (bus.BallEN !== 1'b0 || bus.Miss !== 1'b0) begin bad++;
      $display("FAIL t6_post_reset got=%0b%0b required=00", bus.BallEN, bus.Miss); end
    while (m_beat != 22) begin
      tick();
      if (bus.BallEN === 1'b1) balls++;
    end
    total++; if (balls != 0) begin bad++; $display("FAIL t6_held_ballen got=%0d required=0", balls); end
    bus.K_Press = 1'b0;
    press_at(16);
    total++; if (bus.BallEN !== 1'b1) begin bad++; $display("FAIL t6_repress got=%0b required=1", bus.BallEN); end
    total++; if (bus.Perfect !== 1'b1) begin bad++; $display("FAIL t6_repress_perf got=%0b required=1", bus.Perfect); end
    wait_beat(28);
    total++; if (bus.frame !== 4'd14) begin bad++; $display("FAIL t6_frame28 got=%0d required=14", bus.frame); end
    tick();
    total++; if (bus.frame !== 4'd14) begin bad++; $display("FAIL t6_frame29 got=%0d required=14", bus.frame); end
    tick();
    total++; if (bus.frame !== 4'd15) begin bad++; $display("FAIL t6_frame30 got=%0d required=15", bus.frame); end
    tick();
    total++; if (bus.frame !== 4'd15) begin bad++; $display("FAIL t6_frame31 got=%0d required=15", bus.frame); end
    tick();
    total++; if (bus.frame !== 4'd0) begin bad++; $display("FAIL t6_frame_wrap got=%0d required=0", bus.frame); end
  endtask

  task automatic test_run_freeze();
    bus.Run = 1'b1;
    do_reset();
    wait_beat(15);
    bus.Run = 1'b0;
    tick();
    bus.K_Press = 1'b1;
    tick();
    total++; if (bus.BallEN !== 1'b0) begin bad++; $display("FAIL frz_ballen got=%0b required=0", bus.BallEN); end
    bus.K_Press = 1'b0;
    tick();
    total++; if (bus.frame !== 4'd7) begin bad++; $display("FAIL frz_frame got=%0d required=7", bus.frame); end
    bus.Run = 1'b1;
    press_at(15);
    total++; if (bus.BallEN !== 1'b1) begin bad++; $display("FAIL frz_resume_hit got=%0b required=1", bus.BallEN); end
    total++; if (bus.Combo !== 10'd1) begin bad++; $display("FAIL frz_combo got=%0d required=1", bus.Combo); end
  endtask

  task automatic test_random();
    bus.Run = 1'b1;
    bus.K_Press = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.Run     = ($urandom_range(0, 9) != 0);
      bus.K_Press = ($urandom_range(0, 3) == 0) ? ~bus.K_Press : bus.K_Press;
      Reset       = ($urandom_range(0, 299) == 0);
      tick();
      total++; if (bus.BallEN !== m_ball) begin bad++; $display("FAIL rnd_ballen cyc=%0d got=%0b required=%0b", i, bus.BallEN, m_ball); end
      total++; if (bus.Perfect !== m_perf) begin bad++; $display("FAIL rnd_perfect cyc=%0d got=%0b required=%0b", i, bus.Perfect, m_perf); end
      total++; if (bus.Miss !== m_miss) begin bad++; $display("FAIL rnd_miss cyc=%0d got=%0b required=%0b", i, bus.Miss, m_miss); end
      total++; if (bus.Combo !== 10'(m_combo)) begin bad++; $display("FAIL rnd_combo cyc=%0d got=%0d required=%0d", i, bus.Combo, m_combo); end
      total++; if (bus.frame !== 4'(m_beat / (P / 16))) begin bad++; $display("FAIL rnd_frame cyc=%0d got=%0d required=%0d", i, bus.frame, m_beat / (P / 16)); end
    end
    Reset = 1'b0;
    bus.K_Press = 1'b0;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.K_Press = 1'b0;
    m_beat = 0; m_combo = 0; m_armed = 0; m_finished = 0; m_kprev = 1;
    m_ball = 0; m_perf = 0; m_miss = 0;
    test_reset();
    test_hit_perfect();
    test_back_to_back();
    test_early_press();
    test_timeout_miss();
    test_run_freeze();
    test_reset_held_key();
    test_combo_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
